// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO buffer: push/pop operation encoding and
// the width helpers used to size the occupancy counter and memory address.
package lifo_pkg;

  // Encoding matches the concatenation {push, pop}.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    SWAP = 2'b11
  } op_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lifo_buffer_if.sv
// Request/response bundle of the LIFO buffer. The master drives requests,
// the slave (the buffer) drives data, occupancy and status flags.
interface lifo_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = lifo_pkg::count_width(DEPTH);

  logic             clear;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, push, push_data, pop,
    input  pop_data, pop_valid, top, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clear, push, push_data, pop,
    output pop_data, pop_valid, top, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/lifo_mem.sv
// LIFO storage: WIDTH x DEPTH array with one synchronous write port and one
// asynchronous read port.
module lifo_mem
  import lifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; every read is guarded by count, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_buffer.sv
// LIFO buffer: count is the only control state; flags decode from it directly,
// pops return data one cycle later, and push+pop together swap the top entry.
module lifo_buffer
  import lifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic          clk,
  input logic          rst,
  lifo_buffer_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = addr_width(DEPTH);

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             overflow;
  logic             underflow;

  logic             full;
  logic             empty;
  op_e              op;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  assign op    = op_e'({bus.push, bus.pop});
  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);

  // Top-of-stack address; parked at 0 when empty so it never leaves the array.
  assign rd_addr = empty ? '0 : AW'(count - CW'(1));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    we    = 1'b0;
    waddr = rd_addr;
    if (!rst && !bus.clear) begin
      case (op)
        PUSH: if (!full) begin
          we    = 1'b1;
          waddr = AW'(count);
        end
        SWAP: we = !empty;
        default: we = 1'b0;
      endcase
    end
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.push_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clear) begin
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      case (op)
        PUSH: begin
          if (full) overflow <= 1'b1;
          else      count    <= count + CW'(1);
        end
        POP: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            pop_data  <= rd_data;
            pop_valid <= 1'b1;
            count     <= count - CW'(1);
          end
        end
        SWAP: begin
          // Empty swap bypasses storage: the pushed word is returned directly.
          pop_data  <= empty ? bus.push_data : rd_data;
          pop_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pop_data     = pop_data;
  assign bus.pop_valid    = pop_valid;
  assign bus.top          = empty ? '0 : rd_data;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_LVL);
  assign bus.almost_empty = (count <= AE_LVL);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
